// File: rtl/exception_ctrl.sv
// ---------------------------------------------------------------------------
// exception_ctrl
//
// Purpose: detects and prioritises exceptions for the instruction in the MEM
// stage of the MIPS pipeline. It merges the per-instruction exception flags
// with the pending-interrupt condition and drives the CP0 exception interface
// (excepttype, faulting PC, delay-slot flag, BadVAddr). It also drives the
// pipeline flush and a PC redirect toward fetch. If fetch is stalled, the
// redirect is held until it is accepted.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   mem_valid                MEM holds a real instruction
//   mem_pc, mem_in_delayslot PC and delay-slot flag of the MEM instruction
//   mem_if_adel .. mem_st_ades
//                            exception flags carried with the instruction
//   mem_data_addr            load/store effective address
//   cp0_status/cause/epc     current CP0 register values
//   wb_cp0_we/waddr/wdata    MTC0 write happening in WB this cycle
//   excepttype_o             exception code to CP0 (0 = none)
//   current_inst_addr_o      faulting PC to CP0
//   is_in_delayslot_o        delay-slot flag to CP0
//   bad_addr_o               BadVAddr value to CP0
//   flush_o                  flush IF..MEM
//   redirect_valid_o         redirect request to fetch
//   redirect_pc_o            redirect target
//   redirect_ready_i         fetch accepts the redirect this cycle
// ---------------------------------------------------------------------------
module exception_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC00380
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_valid,
  input  logic [31:0] mem_pc,
  input  logic        mem_in_delayslot,
  input  logic        mem_if_adel,
  input  logic        mem_ri,
  input  logic        mem_ov,
  input  logic        mem_syscall,
  input  logic        mem_break,
  input  logic        mem_eret,
  input  logic        mem_ld_adel,
  input  logic        mem_st_ades,
  input  logic [31:0] mem_data_addr,
  input  logic [31:0] cp0_status,
  input  logic [31:0] cp0_cause,
  input  logic [31:0] cp0_epc,
  input  logic        wb_cp0_we,
  input  logic [4:0]  wb_cp0_waddr,
  input  logic [31:0] wb_cp0_wdata,
  output logic [31:0] excepttype_o,
  output logic [31:0] current_inst_addr_o,
  output logic        is_in_delayslot_o,
  output logic [31:0] bad_addr_o,
  output logic        flush_o,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o,
  input  logic        redirect_ready_i
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] target_q, target_d;

  logic [31:0] statusEff;
  logic [31:0] causeEff;
  logic [31:0] epcEff;
  logic        intPending;
  logic [31:0] excCode;
  logic [31:0] excBadAddr;
  logic [31:0] excTarget;
  logic        excDetect;
  logic        unused_ok;

  // An MTC0 in WB writes CP0 on the same edge on which we act. Its data
  // therefore has to be forwarded here, or we would decide on stale values.
  assign statusEff = (wb_cp0_we && (wb_cp0_waddr == 5'd12)) ? wb_cp0_wdata : cp0_status;
  assign epcEff    = (wb_cp0_we && (wb_cp0_waddr == 5'd14)) ? wb_cp0_wdata : cp0_epc;

  // Only the software-writable Cause fields (IP1..IP0, IV, WP) take the
  // forwarded value. The hardware interrupt lines stay as CP0 reports them.
  always_comb begin
    causeEff = cp0_cause;
    if (wb_cp0_we && (wb_cp0_waddr == 5'd13)) begin
      causeEff[9:8] = wb_cp0_wdata[9:8];
      causeEff[23]  = wb_cp0_wdata[23];
      causeEff[22]  = wb_cp0_wdata[22];
    end
  end

  assign intPending = (|(causeEff[15:8] & statusEff[15:8])) && statusEff[0] && !statusEff[1];

  // Fixed priority chain. An interrupt outranks every instruction flag,
  // including ERET.
  always_comb begin
    excCode    = 32'h0;
    excBadAddr = 32'h0;
    if (intPending) begin
      excCode = 32'h1;
    end else if (mem_if_adel) begin
      excCode    = 32'h4;
      excBadAddr = mem_pc;
    end else if (mem_ri) begin
      excCode = 32'ha;
    end else if (mem_ov) begin
      excCode = 32'hc;
    end else if (mem_syscall) begin
      excCode = 32'h8;
    end else if (mem_break) begin
      excCode = 32'h9;
    end else if (mem_eret) begin
      excCode = 32'he;
    end else if (mem_ld_adel) begin
      excCode    = 32'h4;
      excBadAddr = mem_data_addr;
    end else if (mem_st_ades) begin
      excCode    = 32'h5;
      excBadAddr = mem_data_addr;
    end
  end

  assign excTarget = (excCode == 32'he) ? epcEff : EXC_VECTOR;

  // Outputs must read zero while reset is held. For that reason reset also
  // gates detection combinationally.
  assign excDetect = rst_n && mem_valid && (state_q == IDLE) && (excCode != 32'h0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      target_q <= 32'h0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
    end
  end

  // A code is reported to CP0 only in the detection cycle. HOLD only keeps
  // the flush and the latched redirect alive until fetch takes it.
  always_comb begin
    state_d             = state_q;
    target_d            = target_q;
    excepttype_o        = 32'h0;
    current_inst_addr_o = 32'h0;
    is_in_delayslot_o   = 1'b0;
    bad_addr_o          = 32'h0;
    flush_o             = 1'b0;
    redirect_valid_o    = 1'b0;
    redirect_pc_o       = 32'h0;
    case (state_q)
      IDLE: begin
        if (excDetect) begin
          excepttype_o        = excCode;
          current_inst_addr_o = mem_pc;
          is_in_delayslot_o   = mem_in_delayslot;
          bad_addr_o          = excBadAddr;
          flush_o             = 1'b1;
          redirect_valid_o    = 1'b1;
          redirect_pc_o       = excTarget;
          if (!redirect_ready_i) begin
            state_d  = HOLD;
            target_d = excTarget;
          end
        end
      end
      HOLD: begin
        flush_o          = 1'b1;
        redirect_valid_o = 1'b1;
        redirect_pc_o    = target_q;
        if (redirect_ready_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign unused_ok = ^{statusEff[31:16], statusEff[7:2], causeEff[31:16], causeEff[7:0]};

endmodule

// File: tb/tb_exception_ctrl.sv
// ---------------------------------------------------------------------------
// tb_exception_ctrl
//
// Self-checking bench for exception_ctrl. It applies a table of single-cycle
// vectors, some hand-written multi-cycle sequences (held redirect, reset
// while holding) and a randomized run. The randomized run is compared with a
// reference model written from the priority and forwarding rules.
// ---------------------------------------------------------------------------
module tb_exception_ctrl;

  localparam logic [31:0] VEC = 32'hBFC00380;

  localparam logic [7:0] F_IFADEL = 8'h80;
  localparam logic [7:0] F_RI     = 8'h40;
  localparam logic [7:0] F_OV     = 8'h20;
  localparam logic [7:0] F_SYS    = 8'h10;
  localparam logic [7:0] F_BRK    = 8'h08;
  localparam logic [7:0] F_ERET   = 8'h04;
  localparam logic [7:0] F_LDADEL = 8'h02;
  localparam logic [7:0] F_STADES = 8'h01;

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic        dslot;
    logic [7:0]  flags;
    logic [31:0] daddr;
    logic [31:0] status;
    logic [31:0] cause;
    logic [31:0] epc;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        ready;
  } stim_t;

  typedef struct {
    logic [31:0] exc;
    logic [31:0] cia;
    logic        ds;
    logic [31:0] bad;
    logic        flush;
    logic        rv;
    logic [31:0] rpc;
  } exp_t;

  typedef struct {
    string name;
    stim_t s;
    exp_t  e;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_valid;
  logic [31:0] mem_pc;
  logic        mem_in_delayslot;
  logic        mem_if_adel, mem_ri, mem_ov, mem_syscall;
  logic        mem_break, mem_eret, mem_ld_adel, mem_st_ades;
  logic [31:0] mem_data_addr;
  logic [31:0] cp0_status, cp0_cause, cp0_epc;
  logic        wb_cp0_we;
  logic [4:0]  wb_cp0_waddr;
  logic [31:0] wb_cp0_wdata;
  logic [31:0] excepttype_o;
  logic [31:0] current_inst_addr_o;
  logic        is_in_delayslot_o;
  logic [31:0] bad_addr_o;
  logic        flush_o;
  logic        redirect_valid_o;
  logic [31:0] redirect_pc_o;
  logic        redirect_ready_i;

  int errCount   = 0;
  int checkCount = 0;

  always #5 clk = ~clk;

  exception_ctrl dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .mem_valid           (mem_valid),
    .mem_pc              (mem_pc),
    .mem_in_delayslot    (mem_in_delayslot),
    .mem_if_adel         (mem_if_adel),
    .mem_ri              (mem_ri),
    .mem_ov              (mem_ov),
    .mem_syscall         (mem_syscall),
    .mem_break           (mem_break),
    .mem_eret            (mem_eret),
    .mem_ld_adel         (mem_ld_adel),
    .mem_st_ades         (mem_st_ades),
    .mem_data_addr       (mem_data_addr),
    .cp0_status          (cp0_status),
    .cp0_cause           (cp0_cause),
    .cp0_epc             (cp0_epc),
    .wb_cp0_we           (wb_cp0_we),
    .wb_cp0_waddr        (wb_cp0_waddr),
    .wb_cp0_wdata        (wb_cp0_wdata),
    .excepttype_o        (excepttype_o),
    .current_inst_addr_o (current_inst_addr_o),
    .is_in_delayslot_o   (is_in_delayslot_o),
    .bad_addr_o          (bad_addr_o),
    .flush_o             (flush_o),
    .redirect_valid_o    (redirect_valid_o),
    .redirect_pc_o       (redirect_pc_o),
    .redirect_ready_i    (redirect_ready_i)
  );

  // Returns a quiet stimulus: a valid instruction with no flags, and
  // fetch ready.
  function automatic stim_t baseStim();
    stim_t s;
    s.valid  = 1'b1;
    s.pc     = 32'hBFC00100;
    s.dslot  = 1'b0;
    s.flags  = 8'h00;
    s.daddr  = 32'h0;
    s.status = 32'h0;
    s.cause  = 32'h0;
    s.epc    = 32'h0;
    s.we     = 1'b0;
    s.waddr  = 5'd0;
    s.wdata  = 32'h0;
    s.ready  = 1'b1;
    return s;
  endfunction

  function automatic exp_t mkExp(input logic [31:0] exc, input logic [31:0] cia,
                                 input logic ds, input logic [31:0] bad,
                                 input logic [31:0] rpc);
    exp_t e;
    e.exc   = exc;
    e.cia   = cia;
    e.ds    = ds;
    e.bad   = bad;
    e.flush = (exc != 32'h0);
    e.rv    = (exc != 32'h0);
    e.rpc   = rpc;
    return e;
  endfunction

  function automatic exp_t zeroExp();
    return mkExp(32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
  endfunction

  function automatic exp_t holdExp(input logic [31:0] rpc);
    exp_t e;
    e       = zeroExp();
    e.flush = 1'b1;
    e.rv    = 1'b1;
    e.rpc   = rpc;
    return e;
  endfunction

  // Reference model. It builds the list of candidate causes in priority
  // order and reports the first one that is active.
  function automatic exp_t modelOut(input stim_t s, input bit hold, input logic [31:0] held);
    exp_t        e;
    logic [31:0] st, ca, ep;
    logic        intr, found;
    logic        cond[9];
    logic [31:0] codes[9];
    e = zeroExp();
    if (hold) return holdExp(held);
    if (!s.valid) return e;
    st = (s.we && s.waddr == 5'd12) ? s.wdata : s.status;
    ep = (s.we && s.waddr == 5'd14) ? s.wdata : s.epc;
    ca = s.cause;
    if (s.we && s.waddr == 5'd13) begin
      ca[9:8] = s.wdata[9:8];
      ca[23]  = s.wdata[23];
      ca[22]  = s.wdata[22];
    end
    intr  = ((ca[15:8] & st[15:8]) != 8'h0) && st[0] && !st[1];
    codes = '{32'h1, 32'h4, 32'ha, 32'hc, 32'h8, 32'h9, 32'he, 32'h4, 32'h5};
    cond[0] = intr;
    for (int i = 0; i < 8; i++) cond[i+1] = s.flags[7-i];
    found = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (!found && cond[i]) begin
        found = 1'b1;
        e.exc = codes[i];
        if (i == 1) e.bad = s.pc;
        else if (i >= 7) e.bad = s.daddr;
      end
    end
    if (found) begin
      e.cia   = s.pc;
      e.ds    = s.dslot;
      e.flush = 1'b1;
      e.rv    = 1'b1;
      e.rpc   = (e.exc == 32'he) ? ep : VEC;
    end
    return e;
  endfunction

  // Drives every DUT input from one stimulus record.
  task automatic applyStimulus(input stim_t s);
    mem_valid        = s.valid;
    mem_pc           = s.pc;
    mem_in_delayslot = s.dslot;
    {mem_if_adel, mem_ri, mem_ov, mem_syscall,
     mem_break, mem_eret, mem_ld_adel, mem_st_ades} = s.flags;
    mem_data_addr    = s.daddr;
    cp0_status       = s.status;
    cp0_cause        = s.cause;
    cp0_epc          = s.epc;
    wb_cp0_we        = s.we;
    wb_cp0_waddr     = s.waddr;
    wb_cp0_wdata     = s.wdata;
    redirect_ready_i = s.ready;
  endtask

  task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] expv);
    checkCount++;
    if (act !== expv) begin
      errCount++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Compares all outputs against a record. When full is 0, the CP0 side-band
  // fields are skipped; this is used while a redirect is being held.
  task automatic checkOutput(input string tag, input exp_t e, input bit full);
    checkField({tag, ".excepttype"}, excepttype_o, e.exc);
    checkField({tag, ".flush"}, {31'h0, flush_o}, {31'h0, e.flush});
    checkField({tag, ".redirect_valid"}, {31'h0, redirect_valid_o}, {31'h0, e.rv});
    checkField({tag, ".redirect_pc"}, redirect_pc_o, e.rpc);
    if (full) begin
      checkField({tag, ".inst_addr"}, current_inst_addr_o, e.cia);
      checkField({tag, ".delayslot"}, {31'h0, is_in_delayslot_o}, {31'h0, e.ds});
      checkField({tag, ".bad_addr"}, bad_addr_o, e.bad);
    end
  endtask

  vec_t  vecs[11];
  stim_t s;
  bit    mHold;
  logic [31:0] mHeld;
  exp_t  me;

  initial begin
    // Fill the single-cycle vector table. Ready is high throughout, so the
    // DUT stays in IDLE between rows.
    for (int i = 0; i < 11; i++) vecs[i].s = baseStim();
    vecs[0].name = "ov";
    vecs[0].s.flags = F_OV;
    vecs[0].e = mkExp(32'hc, 32'hBFC00100, 1'b0, 32'h0, VEC);
    vecs[1].name = "eret_fwd_epc";
    vecs[1].s.flags = F_ERET; vecs[1].s.epc = 32'hBFC00200;
    vecs[1].s.we = 1'b1; vecs[1].s.waddr = 5'd14; vecs[1].s.wdata = 32'hBFC00300;
    vecs[1].e = mkExp(32'he, 32'hBFC00100, 1'b0, 32'h0, 32'hBFC00300);
    vecs[2].name = "int_over_sys";
    vecs[2].s.flags = F_SYS; vecs[2].s.status = 32'h401; vecs[2].s.cause = 32'h400;
    vecs[2].e = mkExp(32'h1, 32'hBFC00100, 1'b0, 32'h0, VEC);
    vecs[3].name = "exl_blocks_int";
    vecs[3].s.flags = F_SYS; vecs[3].s.status = 32'h403; vecs[3].s.cause = 32'h400;
    vecs[3].e = mkExp(32'h8, 32'hBFC00100, 1'b0, 32'h0, VEC);
    vecs[4].name = "ifadel_prio";
    vecs[4].s.flags = F_IFADEL | F_RI | F_BRK; vecs[4].s.pc = 32'hBFC00001;
    vecs[4].e = mkExp(32'h4, 32'hBFC00001, 1'b0, 32'hBFC00001, VEC);
    vecs[5].name = "not_valid";
    vecs[5].s.flags = F_IFADEL | F_RI | F_BRK; vecs[5].s.pc = 32'hBFC00001;
    vecs[5].s.valid = 1'b0;
    vecs[5].e = zeroExp();
    vecs[6].name = "st_ades";
    vecs[6].s.flags = F_STADES; vecs[6].s.daddr = 32'h12345671;
    vecs[6].e = mkExp(32'h5, 32'hBFC00100, 1'b0, 32'h12345671, VEC);
    vecs[7].name = "mtc0_ie_off";
    vecs[7].s.flags = F_SYS; vecs[7].s.status = 32'h401; vecs[7].s.cause = 32'h400;
    vecs[7].s.we = 1'b1; vecs[7].s.waddr = 5'd12; vecs[7].s.wdata = 32'h400;
    vecs[7].e = mkExp(32'h8, 32'hBFC00100, 1'b0, 32'h0, VEC);
    vecs[8].name = "int_masks_eret";
    vecs[8].s.flags = F_ERET; vecs[8].s.status = 32'h401; vecs[8].s.cause = 32'h400;
    vecs[8].s.epc = 32'hBFC00200;
    vecs[8].e = mkExp(32'h1, 32'hBFC00100, 1'b0, 32'h0, VEC);
    vecs[9].name = "fwd_cause_swint";
    vecs[9].s.status = 32'h101;
    vecs[9].s.we = 1'b1; vecs[9].s.waddr = 5'd13; vecs[9].s.wdata = 32'h100;
    vecs[9].e = mkExp(32'h1, 32'hBFC00100, 1'b0, 32'h0, VEC);
    vecs[10].name = "ri_dslot";
    vecs[10].s.flags = F_RI | F_SYS; vecs[10].s.dslot = 1'b1; vecs[10].s.pc = 32'h80001234;
    vecs[10].e = mkExp(32'ha, 32'h80001234, 1'b1, 32'h0, VEC);

    // Outputs must stay quiet while reset is held, even with an exception
    // present on the inputs.
    rst_n = 1'b0;
    applyStimulus(vecs[0].s);
    #3;
    checkOutput("reset", zeroExp(), 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i].s);
      #1;
      checkOutput(vecs[i].name, vecs[i].e, 1'b1);
    end

    // Load ADEL with fetch stalled for three cycles. The code appears only
    // in the first cycle. The redirect is held until it is accepted in the
    // fourth cycle.
    @(negedge clk);
    s = baseStim();
    s.flags = F_LDADEL; s.daddr = 32'h80000003; s.ready = 1'b0;
    applyStimulus(s);
    #1;
    checkOutput("ldadel_c0", mkExp(32'h4, 32'hBFC00100, 1'b0, 32'h80000003, VEC), 1'b1);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      s.flags = F_ERET; s.epc = 32'h11110000;
      s.ready = (k == 3);
      applyStimulus(s);
      #1;
      checkOutput($sformatf("ldadel_hold%0d", k), holdExp(VEC), 1'b0);
    end
    @(negedge clk);
    s = baseStim();
    s.ready = 1'b0;
    applyStimulus(s);
    #1;
    checkOutput("ldadel_after", zeroExp(), 1'b1);

    // Reset asserted while holding must drop the redirect at once. The
    // redirect must not return after reset is released.
    @(negedge clk);
    s = baseStim();
    s.flags = F_OV; s.ready = 1'b0;
    applyStimulus(s);
    @(negedge clk);
    #1;
    checkOutput("rst_pre_hold", holdExp(VEC), 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_in_hold", zeroExp(), 1'b1);
    @(negedge clk);
    s = baseStim();
    s.ready = 1'b0;
    applyStimulus(s);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checkOutput($sformatf("rst_after%0d", k), zeroExp(), 1'b1);
      @(negedge clk);
    end

    // Randomized run against the reference model. The DUT is in IDLE here.
    mHold = 1'b0;
    mHeld = 32'h0;
    for (int n = 0; n < 300; n++) begin
      s.valid  = ($urandom_range(0, 7) != 0);
      s.pc     = $urandom;
      s.dslot  = 1'($urandom_range(0, 1));
      for (int b = 0; b < 8; b++) s.flags[b] = ($urandom_range(0, 5) == 0);
      s.daddr  = $urandom;
      s.status = $urandom;
      s.cause  = $urandom;
      s.epc    = $urandom;
      s.we     = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: s.waddr = 5'd12;
        1: s.waddr = 5'd13;
        2: s.waddr = 5'd14;
        default: s.waddr = 5'($urandom_range(0, 31));
      endcase
      s.wdata  = $urandom;
      s.ready  = ($urandom_range(0, 2) != 0);
      applyStimulus(s);
      #1;
      me = modelOut(s, mHold, mHeld);
      checkOutput($sformatf("rand%0d", n), me, !mHold);
      if (mHold) begin
        if (s.ready) mHold = 1'b0;
      end else if (me.exc != 32'h0 && !s.ready) begin
        mHold = 1'b1;
        mHeld = me.rpc;
      end
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
